// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Optional `ALU_PERF_CNT_EN adds a saturating completed-response counter (perf_cnt).
module alu_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [5:0]         req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_carry,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_y,
`ifdef ALU_PERF_CNT_EN
  output logic [15:0]        perf_cnt,
`endif
  input  logic               alu_c
);

  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             gnt;
  logic             g_sel;
  logic             accept;
  logic             rsp_done;
  logic             op_illegal;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [2:0]       op_sel;

  // Both valid: alternate away from the previous winner; otherwise the lone requester wins.
  always_comb begin
    if (req_valid == 2'b11) g_sel = ~last_grant;
    else                    g_sel = req_valid[1];
  end

  assign a_sel      = g_sel ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
  assign b_sel      = g_sel ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
  assign op_sel     = g_sel ? req_op[5:3] : req_op[2:0];
  assign op_illegal = op_sel[2] & op_sel[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready[g_sel] = 1'b1;
          accept           = 1'b1;
          state_nxt        = op_illegal ? RESP : EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[gnt] = 1'b1;
        if (rsp_ready[gnt]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch on accept; illegal ops bypass the ALU and leave alu_* untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        gnt        <= g_sel;
        last_grant <= g_sel;
        if (op_illegal) begin
          rsp_data  <= '0;
          rsp_carry <= 1'b0;
          rsp_err   <= 1'b1;
        end else begin
          alu_a  <= a_sel;
          alu_b  <= b_sel;
          alu_op <= op_sel;
        end
      end
      // Result capture: carry only meaningful for ADD/SUB.
      if (state == EXEC) begin
        rsp_data  <= alu_y;
        rsp_carry <= ((alu_op == OP_ADD) || (alu_op == OP_SUB)) & alu_c;
        rsp_err   <= 1'b0;
      end
    end
  end

`ifdef ALU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            perf_cnt <= 16'h0000;
    else if (rsp_done && (perf_cnt != 16'hFFFF)) perf_cnt <= perf_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural combinational ALU attached.
module tb_alu_share_arbiter;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic [5:0]     req_op = '0;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready = 2'b00;
  logic [W-1:0]   rsp_data;
  logic           rsp_carry;
  logic           rsp_err;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [2:0]     alu_op;
  logic [W-1:0]   alu_y;
  logic           alu_c;
`ifdef ALU_PERF_CNT_EN
  logic [15:0]    perf_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] grant;
    logic       err;
    logic       carry;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y),
`ifdef ALU_PERF_CNT_EN
    .perf_cnt(perf_cnt),
`endif
    .alu_c(alu_c)
  );

  always #5 clk = ~clk;

  // External ALU; carry is deliberately 1 for non-arithmetic ops so masking is observable.
  always_comb begin
    alu_y = 8'hEE;
    alu_c = 1'b1;
    case (alu_op)
      3'd0: alu_y = alu_a & alu_b;
      3'd1: alu_y = alu_a | alu_b;
      3'd2: alu_y = alu_a ^ alu_b;
      3'd3: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd4: {alu_c, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd5: alu_y = ~alu_a;
      default: ;
    endcase
  end

  function automatic exp_t model(input logic [1:0] grant, input logic [2:0] op,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.grant = grant; e.err = 1'b0; e.carry = 1'b0; e.data = 8'h00;
    case (op)
      3'd0: e.data = a & b;
      3'd1: e.data = a | b;
      3'd2: e.data = a ^ b;
      3'd3: begin e.data = 8'(int'(a) + int'(b)); e.carry = (int'(a) + int'(b)) > 255; end
      3'd4: begin e.data = 8'(int'(a) - int'(b)); e.carry = (a < b); end
      3'd5: e.data = ~a;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_op[r*3 +: 3] = op;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    set_req(0, 8'h11, 8'h22, 3'd3);
    set_req(1, 8'h33, 8'h44, 3'd1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    checks++;
    if ({rsp_valid, rsp_data, rsp_carry, rsp_err} !== 12'h000) begin
      failures++; $display("FAIL reset_rsp got=%b/%h/%b/%b want=0", rsp_valid, rsp_data, rsp_carry, rsp_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 19'h0) begin
      failures++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_a, alu_b, alu_op);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_xor_first;
    int cyc; exp_t e;
    @(negedge clk);
    set_req(0, 8'hF0, 8'h3C, 3'd2); req_valid = 2'b01; #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL xor_ready got=%b want=01", req_ready); end
    sbq.push_back(model(2'b01, 3'd2, 8'hF0, 8'h3C));
    @(negedge clk); req_valid = 2'b00; #1;
    checks++;
    if ({req_ready, rsp_valid} !== 4'b0000) begin
      failures++; $display("FAIL xor_exec_quiet got=%b/%b want=00/00", req_ready, rsp_valid);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'hF0, 8'h3C, 3'd2}) begin
      failures++; $display("FAIL xor_alu_drive got=%h/%h/%h want=f0/3c/2", alu_a, alu_b, alu_op);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc !== 1) begin failures++; $display("FAIL xor_latency got=%0d want=1", cyc); end
    e = sbq.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_carry, rsp_data} !== {e.grant, e.err, e.carry, e.data}) begin
      failures++; $display("FAIL xor_rsp got=%b/%b/%b/%h want=%b/%b/%b/%h",
                           rsp_valid, rsp_err, rsp_carry, rsp_data, e.grant, e.err, e.carry, e.data);
    end
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b00) begin failures++; $display("FAIL xor_rsp_clear got=%b want=00", rsp_valid); end
  endtask

  task automatic test_add_sub;
    int cyc; exp_t e;
    logic [7:0] a; logic [2:0] op;
    for (int k = 0; k < 2; k++) begin
      a  = (k == 0) ? 8'hFF : 8'h00;
      op = (k == 0) ? 3'd3 : 3'd4;
      @(negedge clk);
      set_req(1, a, 8'h01, op); req_valid = 2'b10; #1;
      checks++;
      if (req_ready !== 2'b10) begin failures++; $display("FAIL addsub%0d_ready got=%b want=10", k, req_ready); end
      sbq.push_back(model(2'b10, op, a, 8'h01));
      @(negedge clk); req_valid = 2'b00; #1;
      wait_rsp(cyc);
      checks++;
      if (cyc !== 1) begin failures++; $display("FAIL addsub%0d_latency got=%0d want=1", k, cyc); end
      e = sbq.pop_front();
      checks++;
      if ({rsp_valid, rsp_err, rsp_carry, rsp_data} !== {e.grant, e.err, e.carry, e.data}) begin
        failures++; $display("FAIL addsub%0d_rsp got=%b/%b/%b/%h want=%b/%b/%b/%h", k,
                             rsp_valid, rsp_err, rsp_carry, rsp_data, e.grant, e.err, e.carry, e.data);
      end
      rsp_ready = 2'b10;
      @(negedge clk); rsp_ready = 2'b00; #1;
      checks++;
      if (rsp_valid !== 2'b00) begin failures++; $display("FAIL addsub%0d_clear got=%b want=00", k, rsp_valid); end
    end
  endtask

  task automatic test_alternation;
    int cyc; exp_t e;
    logic [1:0] expg; logic [2:0] exop;
    @(negedge clk);
    set_req(0, 8'h12, 8'h34, 3'd3);
    set_req(1, 8'h12, 8'h34, 3'd4);
    req_valid = 2'b11; rsp_ready = 2'b11; #1;
    for (int i = 0; i < 4; i++) begin
      expg = (i % 2 == 0) ? 2'b01 : 2'b10;
      exop = (i % 2 == 0) ? 3'd3 : 3'd4;
      cyc = 0;
      while (req_ready == 2'b00 && cyc < 20) begin @(negedge clk); #1; cyc++; end
      checks++;
      if (req_ready !== expg) begin failures++; $display("FAIL alt%0d_grant got=%b want=%b", i, req_ready, expg); end
      sbq.push_back(model(expg, exop, 8'h12, 8'h34));
      @(negedge clk); #1;
      checks++;
      if (alu_op !== exop) begin failures++; $display("FAIL alt%0d_alu_op got=%0d want=%0d", i, alu_op, exop); end
      wait_rsp(cyc);
      e = sbq.pop_front();
      checks++;
      if ({rsp_valid, rsp_err, rsp_carry, rsp_data} !== {e.grant, e.err, e.carry, e.data}) begin
        failures++; $display("FAIL alt%0d_rsp got=%b/%b/%b/%h want=%b/%b/%b/%h", i,
                             rsp_valid, rsp_err, rsp_carry, rsp_data, e.grant, e.err, e.carry, e.data);
      end
    end
    req_valid = 2'b00;
    @(negedge clk); rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    int cyc; exp_t e;
    @(negedge clk);
    set_req(0, 8'h5A, 8'hA5, 3'd1); req_valid = 2'b01; rsp_ready = 2'b00; #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_ready got=%b want=01", req_ready); end
    sbq.push_back(model(2'b01, 3'd1, 8'h5A, 8'hA5));
    @(negedge clk);
    set_req(1, 8'h77, 8'h11, 3'd0); req_valid = 2'b11; rsp_ready = 2'b10; #1;
    wait_rsp(cyc);
    e = sbq.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_carry, rsp_data} !== {e.grant, e.err, e.carry, e.data}) begin
      failures++; $display("FAIL bp_rsp got=%b/%b/%b/%h want=%b/%b/%b/%h",
                           rsp_valid, rsp_err, rsp_carry, rsp_data, e.grant, e.err, e.carry, e.data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_carry, rsp_data} !== {2'b00, e.grant, e.err, e.carry, e.data}) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%b/%h want=00/%b/%h", i, req_ready, rsp_valid, rsp_data, e.grant, e.data);
      end
    end
    @(negedge clk); rsp_ready = 2'b01; req_valid = 2'b00;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b00) begin failures++; $display("FAIL bp_clear got=%b want=00", rsp_valid); end
  endtask

  task automatic test_illegal;
    int cyc; exp_t e;
    @(negedge clk);
    set_req(0, 8'h33, 8'h44, 3'd7); req_valid = 2'b01; #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL ill_ready got=%b want=01", req_ready); end
    sbq.push_back(model(2'b01, 3'd7, 8'h33, 8'h44));
    @(negedge clk); req_valid = 2'b00; #1;
    wait_rsp(cyc);
    checks++;
    if (cyc !== 0) begin failures++; $display("FAIL ill_latency got=%0d want=0", cyc); end
    e = sbq.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_carry, rsp_data} !== {e.grant, e.err, e.carry, e.data}) begin
      failures++; $display("FAIL ill_rsp got=%b/%b/%b/%h want=%b/%b/%b/%h",
                           rsp_valid, rsp_err, rsp_carry, rsp_data, e.grant, e.err, e.carry, e.data);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h5A, 8'hA5, 3'd1}) begin
      failures++; $display("FAIL ill_alu_hold got=%h/%h/%h want=5a/a5/1", alu_a, alu_b, alu_op);
    end
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b00) begin failures++; $display("FAIL ill_clear got=%b want=00", rsp_valid); end
  endtask

  task automatic test_reset_mid_exec;
    int cyc; exp_t e;
    @(negedge clk);
    set_req(1, 8'h10, 8'h20, 3'd3); req_valid = 2'b10; #1;
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL rst_mid_ready got=%b want=10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    checks++;
    if (alu_op !== 3'd3) begin failures++; $display("FAIL rst_mid_exec got=%0d want=3", alu_op); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, alu_a, alu_b, alu_op} !== 33'h0) begin
      failures++; $display("FAIL rst_mid_async got=%b/%b/%h/%h/%h/%h want=0", req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_op);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_norsp%0d got=%b want=00", i, rsp_valid); end
    end
    @(negedge clk);
    set_req(0, 8'h81, 8'h7F, 3'd3); req_valid = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_mid_grant got=%b want=01", req_ready); end
    sbq.push_back(model(2'b01, 3'd3, 8'h81, 8'h7F));
    @(negedge clk); req_valid = 2'b00; #1;
    wait_rsp(cyc);
    e = sbq.pop_front();
    checks++;
    if ({rsp_valid, rsp_err, rsp_carry, rsp_data} !== {e.grant, e.err, e.carry, e.data}) begin
      failures++; $display("FAIL rst_mid_rsp got=%b/%b/%b/%h want=%b/%b/%b/%h",
                           rsp_valid, rsp_err, rsp_carry, rsp_data, e.grant, e.err, e.carry, e.data);
    end
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 2'b00; #1;
    checks++;
    if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_clear got=%b want=00", rsp_valid); end
`ifdef ALU_PERF_CNT_EN
    checks++;
    if (perf_cnt !== 16'd1) begin failures++; $display("FAIL perf_cnt got=%0d want=1", perf_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_xor_first();
    test_add_sub();
    test_alternation();
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Controller that shares one combinational 8-bit ALU (AND/OR/XOR/ADD/SUB/NOT) between two requesters.
- Round-robin arbitration, valid/ready request and response handshakes, registered operand drive to the ALU, registered result capture.
- Sits between the two client blocks and the structural ALU top. The ALU stays purely combinational; this block owns all sequencing.

Parameters:
- WIDTH, 8, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: requester i's operation accepted this cycle.
- req_a  input  2*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH].
- req_b  input  2*WIDTH  operand B, same packing as req_a.
- req_op  input  6  opcode; requester i at [i*3 +: 3].
- rsp_valid  output  2  bit i: response for requester i is valid.
- rsp_ready  input  2  bit i: requester i takes the response.
- rsp_data  output  WIDTH  result (shared bus, qualified by rsp_valid).
- rsp_carry  output  1  carry/borrow from ADD/SUB, else 0.
- rsp_err  output  1  1 = illegal opcode, rsp_data forced 0.
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- alu_y  input  WIDTH  ALU result.
- alu_c  input  1  ALU carry out.

Behaviour:
- One clock; reset is asynchronous and active-low. All flops clear immediately on rst_n low.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins first).
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_op=0.
  - req_ready=0 while rst_n low.
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (a-b, carry=borrow), 101 NOT a. 110/111 are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the only valid requester if just one is valid. If both are valid, g = ~last_grant.
  - req_ready[g]=1 combinationally; the other bit is 0. req_ready is 0 in all non-IDLE states.
  - On handshake (req_valid[g] & req_ready[g]): latch operands/op into alu_a/alu_b/alu_op, record g, last_grant<=g.
  - Legal op -> EXEC. Illegal op -> RESP with rsp_data=0, rsp_carry=0, rsp_err=1 (ALU not exercised).
- EXEC (1 cycle): capture alu_y -> rsp_data, and alu_c -> rsp_carry only for ADD/SUB (else 0); rsp_err=0; -> RESP.
- RESP:
  - rsp_valid[g]=1, the other bit 0. rsp_data/carry/err hold stable until rsp_ready[g].
  - rsp_ready[g]=1 -> rsp_valid cleared next edge, -> IDLE. rsp_ready on the non-granted bit is ignored.
- Latency: accept at edge T -> rsp_valid high after edge T+2 (legal) or T+1 (illegal). Minimum 3 cycles per legal op, no overlap.
- alu_a/alu_b/alu_op hold their last value outside EXEC (no toggling when idle).
- Requester dropping req_valid while not granted: no effect. Both requesters continuously valid: strict alternation 0,1,0,1...
- Reset mid-EXEC/RESP: operation aborted, no response issued, last_grant returns to 1.

Optional Feature:
- Macro ALU_PERF_CNT_EN.
- Defined: adds output perf_cnt[15:0], reset 0. Increments on each completed response handshake (legal or illegal) and saturates at 16'hFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset release, req_valid=01, req0: a=8'hF0, b=8'h3C, op=010 -> req_ready=01 for one cycle; rsp_valid=01 two cycles later; rsp_data=8'hCC, rsp_carry=0, rsp_err=0.
- req1 ADD a=8'hFF, b=8'h01 -> rsp_data=8'h00, rsp_carry=1; SUB a=8'h00, b=8'h01 -> rsp_data=8'hFF, rsp_carry=1.
- Both valid continuously for 4 ops -> grants 0,1,0,1; alu_op sequence and rsp_valid bits match each grant.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data stable; req_ready stays 00; no new accept until rsp_ready.
- req0 op=111 -> response after 1 cycle, rsp_err=1, rsp_data=0; alu_* unchanged.
- rst_n pulsed low during EXEC -> all outputs zero asynchronously; no rsp_valid afterward; next both-valid grants requester 0.
